rdm_circular_reader: RTL and testbench

- Parametrised rate-dematching reader. It streams one layer of soft bits (LLRs) out of the combine input buffer as fully packed words of LANES LLRs.
- Output starts at an arbitrary element offset and wraps circularly over E elements at element granularity, not word granularity.
- Output handshake is valid/ready with backpressure, so it can feed the combiner directly.
- Supersedes the fixed 16×6-bit reader: adds parametrised widths and layer count, arbitrary start offset, and stall support.

---
 rtl/rdm_circular_reader.sv | 159 +++++++++++++++
 tb/tb_rdm_circular_reader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rdm_circular_reader.sv
// Streams one LLR layer from the combine buffer as packed LANES-wide words, wrapping circularly over E elements.
// First word <=4 cycles after start for full-word reads; 1 word/cycle after that; o_valid/o_data/o_last hold while i_ready is low.
module rdm_circular_reader #(
  parameter int LLR_W  = 6,
  parameter int LANES  = 16,
  parameter int QM_MAX = 8,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 16
) (
  input  logic                           i_core_clk,
  input  logic                           i_rx_rst,
  input  logic                           i_start,
  input  logic [LEN_W-1:0]               i_e_size,
  input  logic [LEN_W-1:0]               i_out_len,
  input  logic [LEN_W-1:0]               i_start_offset,
  input  logic [3:0]                     i_layer_sel,
  output logic                           o_busy,
  output logic                           o_rd_en,
  output logic [ADDR_W-1:0]              o_rd_addr,
  input  logic [LANES*QM_MAX*LLR_W-1:0]  i_rd_data,
  output logic [LANES*LLR_W-1:0]         o_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_last,
  output logic                           o_done
);

  localparam int LB    = $clog2(LANES);
  localparam int DEPTH = 3 * LANES;
  localparam int CW    = LEN_W + 1;
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LMASK   = CW'(LANES - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t                  state_q;
  logic [CW-1:0]           e_q, lastw_q, lastl_q, ep_q, fetch_rem_q, emit_rem_q, cnt_q, infl_n_q;
  logic [3:0]              layer_q;
  logic [LB-1:0]           infl_lane_q;
  logic [LLR_W-1:0]        stage_q [DEPTH];
  logic [LLR_W-1:0]        stage_d [DEPTH];
  logic [LLR_W-1:0]        inc     [LANES];
  logic [LANES*LLR_W-1:0]  data_q, word_asm;
  logic                    valid_q, last_q;

  logic                    active, rd_go, accept, load, layer_ok;
  logic [CW-1:0]           cur_word, word_end, avail, rd_n, sum, ep_next, need, pop, keep, e_m1;
  logic [LB-1:0]           cur_lane;

  always_comb begin
    active   = (state_q == PRIME) || (state_q == RUN);
    cur_word = ep_q >> LB;
    cur_lane = ep_q[LB-1:0];
    // The last buffer word may be only partly populated; never read past element E-1 within it.
    word_end = (cur_word == lastw_q) ? lastl_q : LANES_C;
    avail    = word_end - CW'(cur_lane);
    rd_n     = (avail < fetch_rem_q) ? avail : fetch_rem_q;
    sum      = ep_q + rd_n;
    ep_next  = (sum >= e_q) ? (sum - e_q) : sum;
    rd_go    = active && (fetch_rem_q != '0) && ((cnt_q + infl_n_q + LANES_C) <= DEPTH_C);
    need     = (emit_rem_q < LANES_C) ? emit_rem_q : LANES_C;
    accept   = valid_q && i_ready;
    load     = active && (emit_rem_q != '0) && (!valid_q || accept) && (cnt_q >= need);
    pop      = load ? need : '0;
    keep     = cnt_q - pop;
    e_m1     = {1'b0, i_e_size} - ONE;
    layer_ok = int'(layer_q) < QM_MAX;
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      inc[k] = '0;
      if (layer_ok && (int'(infl_lane_q) + k < LANES))
        inc[k] = i_rd_data[((int'(infl_lane_q) + k) * QM_MAX + int'(layer_q)) * LLR_W +: LLR_W];
    end
  end

  // Staging is a compacting FIFO: survivors shift to the head, arriving elements append behind them.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = '0;
      if (i < int'(keep))
        stage_d[i] = stage_q[i + int'(pop)];
      else if (i - int'(keep) < int'(infl_n_q))
        stage_d[i] = inc[i - int'(keep)];
    end
  end

  always_comb begin
    word_asm = '0;
    for (int i = 0; i < LANES; i++)
      if (i < int'(need)) word_asm[i*LLR_W +: LLR_W] = stage_q[i];
  end

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state_q     <= IDLE;
      e_q         <= '0;
      lastw_q     <= '0;
      lastl_q     <= '0;
      ep_q        <= '0;
      fetch_rem_q <= '0;
      emit_rem_q  <= '0;
      cnt_q       <= '0;
      infl_n_q    <= '0;
      infl_lane_q <= '0;
      layer_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q     <= stage_d;
      cnt_q       <= keep + infl_n_q;
      infl_n_q    <= rd_go ? rd_n : '0;
      infl_lane_q <= cur_lane;
      if (rd_go) begin
        ep_q        <= ep_next;
        fetch_rem_q <= fetch_rem_q - rd_n;
      end
      if (load) begin
        data_q     <= word_asm;
        valid_q    <= 1'b1;
        last_q     <= (emit_rem_q <= LANES_C);
        emit_rem_q <= emit_rem_q - need;
      end else if (accept) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
      case (state_q)
        IDLE: if (i_start) begin
          e_q         <= {1'b0, i_e_size};
          lastw_q     <= e_m1 >> LB;
          lastl_q     <= (e_m1 & LMASK) + ONE;
          layer_q     <= i_layer_sel;
          ep_q        <= {1'b0, i_start_offset};
          fetch_rem_q <= {1'b0, i_out_len};
          emit_rem_q  <= {1'b0, i_out_len};
          state_q     <= (i_out_len == '0) ? DONE : PRIME;
        end
        PRIME: if (load) state_q <= RUN;
        RUN:   if (accept && last_q) state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);
  assign o_rd_en   = rd_go;
  assign o_rd_addr = cur_word[ADDR_W-1:0];
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_last    = last_q;

endmodule

// File: tb/tb_rdm_circular_reader.sv
// Directed bench for rdm_circular_reader: buffer content is a closed-form function of (word, lane, layer),
// expected words are rebuilt from the element mapping (k0+j) mod E.
module tb_rdm_circular_reader;

  logic         clk = 1'b0;
  logic         rst, start, ready;
  logic [15:0]  e_size, out_len, k0;
  logic [3:0]   layer;
  logic         busy, rd_en, valid, last, done;
  logic [11:0]  rd_addr;
  logic [767:0] rd_data = '1;
  logic [95:0]  data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rdm_circular_reader dut (
    .i_core_clk(clk), .i_rx_rst(rst), .i_start(start),
    .i_e_size(e_size), .i_out_len(out_len), .i_start_offset(k0), .i_layer_sel(layer),
    .o_busy(busy), .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_data(data), .o_valid(valid), .i_ready(ready), .o_last(last), .o_done(done)
  );

  function automatic logic [5:0] llr(int w, int l, int q);
    return 6'((w * 13 + l * 5 + q * 11 + 7) & 63);
  endfunction

  function automatic logic [767:0] mem_word(int a);
    logic [767:0] r = '0;
    for (int l = 0; l < 16; l++)
      for (int q = 0; q < 8; q++) r[(l * 8 + q) * 6 +: 6] = llr(a, l, q);
    return r;
  endfunction

  function automatic logic [95:0] exp_word(int e, int n, int ko, int q, int w);
    logic [95:0] r = '0;
    for (int i = 0; i < 16; i++) begin
      int j = w * 16 + i;
      if (j < n && q < 8) begin
        int el = (ko + j) % e;
        r[i * 6 +: 6] = llr(el / 16, el % 16, q);
      end
    end
    return r;
  endfunction

  // Buffer model: one-cycle read latency, garbage when not reading
  always @(posedge clk) rd_data <= rd_en ? mem_word(int'(rd_addr)) : '1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_case(input string tag, input int e, input int n, input int ko, input int q,
                          input int mode, input bit poke, input int rd_max, input int lat_max);
    int w_cnt = (n + 15) / 16;
    int widx = 0, rd_cnt = 0, first_v = -1, done_c = -1, last_acc = -1;
    bit stall = 0;
    logic [96:0] held = '0;
    @(negedge clk);
    e_size = 16'(e); out_len = 16'(n); k0 = 16'(ko); layer = 4'(q);
    start = 1'b1;
    ready = (mode == 0);
    for (int cyc = 1; cyc <= 400 && done_c < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && cyc == 3) begin
        start = 1'b1; e_size = 16'd5; out_len = 16'd20; k0 = 16'd3; layer = 4'd1;
      end
      ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 1) || (cyc % 4 == 0));
      if (rd_en) rd_cnt++;
      if (valid) begin
        if (first_v < 0) first_v = cyc;
        if (stall) chk($sformatf("%s/hold%0d", tag, widx), {last, data}, held);
        if (ready) begin
          chk($sformatf("%s/w%0d", tag, widx), data, exp_word(e, n, ko, q, widx));
          chk($sformatf("%s/last%0d", tag, widx), last, widx == w_cnt - 1);
          widx++;
          stall = 0;
          last_acc = cyc;
        end else begin
          stall = 1;
          held = {last, data};
        end
      end
      if (done) done_c = cyc;
    end
    chk({tag, "/words"}, widx, w_cnt);
    chk({tag, "/done_seen"}, done_c > 0, 1);
    chk({tag, "/rd_cnt_ok"}, rd_cnt <= rd_max, 1);
    if (n == 0) begin
      chk({tag, "/done_lat"}, done_c <= 2, 1);
      chk({tag, "/no_valid"}, first_v < 0, 1);
    end else begin
      chk({tag, "/done_next"}, done_c - last_acc, 1);
    end
    if (lat_max > 0) chk({tag, "/latency"}, first_v > 0 && first_v <= lat_max, 1);
    @(negedge clk);
    chk({tag, "/idle"}, {busy, done, valid}, 3'b000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    e_size = '0; out_len = '0; k0 = '0; layer = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, rd_en, valid, last, done, rd_addr, data}, '0);
    rst = 1'b0;

    run_case("default", 64, 64, 0, 2, 0, 1'b0, 5, 4);
    run_case("wrap", 40, 48, 30, 3, 0, 1'b0, 100, 0);
    run_case("tinyE", 5, 20, 3, 1, 0, 1'b0, 100, 0);
    run_case("backpr", 64, 64, 0, 2, 1, 1'b0, 5, 0);
    run_case("n0", 10, 0, 0, 2, 0, 1'b0, 0, 0);
    run_case("layer9", 64, 32, 5, 9, 0, 1'b0, 100, 0);
    run_case("busy_start", 64, 64, 0, 2, 0, 1'b1, 5, 4);

    // Mid-run reset, with a start pulse in the same cycle that must lose
    @(negedge clk);
    e_size = 16'd64; out_len = 16'd64; k0 = 16'd0; layer = 4'd2; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
    chk("midrst/running", valid, 1'b1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("midrst/outs", {busy, rd_en, valid, last, done, rd_addr, data}, '0);
    @(negedge clk);
    chk("midrst/start_lost", {busy, done}, 2'b00);
    run_case("after_rst", 64, 64, 0, 2, 0, 1'b0, 5, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
